// File: rtl/cla_add_sequencer_if.sv
// cla_add_sequencer_if
//   Bundles the three buses around the wide-add sequencer:
//   - request side : in_valid/in_ready handshake with operands in_a, in_b, in_cin
//   - adder side   : add_number1/add_number2/add_cin out, add_sum/add_cout back
//   - result side  : out_valid/out_ready handshake with out_sum, out_cout
//   Modport slave is the sequencer's view; modport master is the view of the
//   environment (request source, adder and result sink together).
interface cla_add_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int WORDS = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*WORDS-1:0]   in_a;
    logic [WIDTH*WORDS-1:0]   in_b;
    logic                     in_cin;
    logic [WIDTH-1:0]         add_number1;
    logic [WIDTH-1:0]         add_number2;
    logic                     add_cin;
    logic [WIDTH-1:0]         add_sum;
    logic                     add_cout;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH*WORDS-1:0]   out_sum;
    logic                     out_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_number1, add_number2, add_cin, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_number1, add_number2, add_cin, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer
//   Splits one WORDS*WIDTH-bit addition into WORDS passes through a single
//   registered WIDTH-bit adder of latency LAT, least-significant word first,
//   chaining each pass's carry-out into the next pass's carry-in, and returns
//   the assembled wide sum on a valid/ready handshake.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - cla_add_sequencer_if.slave: request handshake + operands,
//           adder operand/result ports, result handshake + wide sum/carry
module cla_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int WORDS = 2,
    parameter int LAT   = 2
) (
    input  logic               clk,
    input  logic               reset,
    cla_add_sequencer_if.slave bus
);
    localparam int TOT   = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [TOT-1:0]   a_reg, a_next;
    logic [TOT-1:0]   b_reg, b_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] n1_reg, n1_next;
    logic [WIDTH-1:0] n2_reg, n2_next;
    logic             cin_reg, cin_next;
    logic             cout_reg, cout_next;
    logic             sample_word;

    // The adder result for the current word is valid on this edge.
    assign sample_word = (state_reg == RUN) && (cnt_reg == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            n1_reg    <= '0;
            n2_reg    <= '0;
            cin_reg   <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            n1_reg    <= n1_next;
            n2_reg    <= n2_next;
            cin_reg   <= cin_next;
            cout_reg  <= cout_next;
        end
    end

    // The operand registers hold only the words not yet sent to the adder,
    // shifted down so the next word to issue always sits at the bottom.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        n1_next    = n1_reg;
        n2_next    = n2_reg;
        cin_next   = cin_reg;
        cout_next  = cout_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next     = bus.in_a >> WIDTH;
                    b_next     = bus.in_b >> WIDTH;
                    n1_next    = bus.in_a[WIDTH-1:0];
                    n2_next    = bus.in_b[WIDTH-1:0];
                    cin_next   = bus.in_cin;
                    idx_next   = '0;
                    cnt_next   = CNT_INIT;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (idx_reg != IDX_LAST) begin
                    a_next   = a_reg >> WIDTH;
                    b_next   = b_reg >> WIDTH;
                    n1_next  = a_reg[WIDTH-1:0];
                    n2_next  = b_reg[WIDTH-1:0];
                    cin_next = bus.add_cout;
                    idx_next = idx_reg + 1'b1;
                    cnt_next = CNT_INIT;
                end else begin
                    cout_next  = bus.add_cout;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One result register per word; each loads only on its own pass.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_sum
        logic [WIDTH-1:0] word_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word_reg <= '0;
            end else if (sample_word && (idx_reg == IDX_W'(gi))) begin
                word_reg <= bus.add_sum;
            end
        end

        assign bus.out_sum[gi*WIDTH +: WIDTH] = word_reg;
    end

    assign bus.in_ready    = (state_reg == IDLE);
    assign bus.out_valid   = (state_reg == DONE);
    assign bus.add_number1 = n1_reg;
    assign bus.add_number2 = n2_reg;
    assign bus.add_cin     = cin_reg;
    assign bus.out_cout    = cout_reg;
endmodule

// File: doc/cla_add_sequencer.md
# cla_add_sequencer

Upstream operand sequencer for the registered 32-bit carry-lookahead adder. It accepts one wide addition request (WORDS × WIDTH bits) over a valid/ready handshake and feeds the adder one WIDTH-bit word per pass, least-significant word first. It chains each returned carry-out into the next pass's carry-in, assembles the wide sum, and presents it downstream on a second valid/ready handshake. This lets 64-bit and wider additions reuse the single 32-bit adder instance.

## Interface
Parameters:
- WIDTH, 32: adder word width; must match the adder's operand width.
- WORDS, 2: words per request; ≥ 1.
- LAT, 2: adder latency in rising edges, from the edge that changes add_number1/add_number2/add_cin to the edge at which add_sum/add_cout are valid to sample; ≥ 1.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = in reset).
- in_valid, input, 1: request valid.
- in_ready, output, 1: request accepted when in_valid & in_ready at a rising edge.
- in_a, input, WIDTH*WORDS: operand A.
- in_b, input, WIDTH*WORDS: operand B.
- in_cin, input, 1: carry-in to word 0.
- add_number1, output, WIDTH: registered word of A to the adder.
- add_number2, output, WIDTH: registered word of B to the adder.
- add_cin, output, 1: registered carry to the adder.
- add_sum, input, WIDTH: adder sum.
- add_cout, input, 1: adder carry-out.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result when out_valid & out_ready at a rising edge.
- out_sum, output, WIDTH*WORDS: wide sum.
- out_cout, output, 1: carry-out of the most-significant word.

## Operation
- States: IDLE, RUN, DONE. Internal registers: operand registers A and B, word index idx (0..WORDS-1), latency counter cnt (0..LAT-1), and the sum accumulator.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept: latch in_a and in_b; drive add_number1=in_a word 0, add_number2=in_b word 0, add_cin=in_cin; set idx=0, cnt=LAT-1; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - While cnt≠0: decrement cnt; adder ports hold their values.
  - When cnt=0, the edge samples add_sum into out_sum word idx.
  - If idx<WORDS-1: drive word idx+1 of A and B, set add_cin=add_cout, idx+1, cnt=LAT-1.
  - Else: out_cout=add_cout; go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum and out_cout are held stable until accepted.
  - On out_ready: go to IDLE. No request is accepted in the same cycle.
- Adder ports keep their last driven values in IDLE and DONE.
- out_sum and out_cout hold their last value after the transfer. Partially built words are not guaranteed stable until out_valid=1.
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, mod 2^(WIDTH*WORDS+1).
- Reset (reset=0), asynchronous, including mid-RUN or in DONE:
  - state=IDLE; idx, cnt, add_number1, add_number2, add_cin, out_sum, out_cout all 0; out_valid=0; in_ready=1.
  - Any in-flight request is discarded.
  - After deassertion, the first accept is legal on the first rising edge.

## Timing
- in_ready and out_valid decode from state only: in_ready=(state==IDLE), out_valid=(state==DONE).
- Word k operands change at accept edge t0 + k·LAT.
- Word k result is sampled at edge t0 + (k+1)·LAT.
- out_valid rises after edge t0 + WORDS·LAT. With defaults: 4 cycles after accept.
- Throughput: one request per WORDS·LAT + 2 cycles when out_ready=1. With defaults: 6 cycles.
- Backpressure in DONE: unlimited hold, no loss.
- WORDS=1: a single pass; out_cout is the adder's cout.

## Test plan
- a=0x00000000_FFFFFFFF, b=0x1, cin=0 (defaults) -> out_sum=0x00000001_00000000, out_cout=0, out_valid high in cycle 4 after accept; add_cin=1 during pass 2.
- a=b=0xFFFFFFFF_FFFFFFFF, cin=1 -> out_sum=0xFFFFFFFF_FFFFFFFF, out_cout=1.
- Request accepted, then out_ready=0 for 5 cycles with in_valid pulsing -> out_valid, out_sum, and out_cout stable; in_ready=0; no extra accept. Transfer completes when out_ready rises.
- reset pulled low at cycle 2 of RUN -> all outputs 0 and in_ready=1 immediately. A new request 0x5+0x3 then yields 0x8, with no stale data.
- in_valid held high with two queued requests (0x1+0x1, then 0x2+0x2), out_ready=1 -> accepts 6 cycles apart; results 0x2 then 0x4, in order.
- 1000 random requests with LAT=1 and LAT=3, WORDS=1/2/4, random out_ready, against a behavioural adder of matching latency -> every result matches the reference sum and cycle-count formula.
